// File: rtl/router_1x3.sv
// 1-input, 3-output byte packet router: steers packets to three FIFOs by header address,
// accumulates byte-XOR parity and flags a mismatch, and flushes FIFOs left unread too long.
module router_1x3 #(
    parameter int DEPTH             = 16,
    parameter int SOFT_RESET_CYCLES = 30
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] data_in,
    input  logic       pkt_valid,
    input  logic       read_enb_0,
    input  logic       read_enb_1,
    input  logic       read_enb_2,
    output logic [7:0] data_out_0,
    output logic [7:0] data_out_1,
    output logic [7:0] data_out_2,
    output logic       valid_out_0,
    output logic       valid_out_1,
    output logic       valid_out_2,
    output logic       busy,
    output logic       error
);

    // DEPTH is a power of two so the pointers wrap by plain overflow
    localparam int              AW         = $clog2(DEPTH);
    localparam int              CW         = $clog2(SOFT_RESET_CYCLES + 1);
    localparam logic [AW:0]     FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0]   LAST_IDLE  = CW'(SOFT_RESET_CYCLES - 1);

    typedef enum logic [2:0] {
        DECODE,
        WAIT_EMPTY,
        LOAD_FIRST,
        LOAD_DATA,
        FIFO_FULL,
        CHECK_PARITY,
        DROP
    } state_t;

    state_t          state;
    logic [7:0]      header_reg;
    logic [7:0]      parity_acc;
    logic [7:0]      recv_parity;
    logic [1:0]      addr_reg;

    logic [2:0]      read_req;
    logic [2:0]      full;
    logic [2:0]      empty;
    logic [2:0]      rd_en;
    logic [2:0]      wr_en;
    logic [2:0]      soft_rst;
    logic [2:0]      valid_vec;
    logic [2:0][7:0] dout_vec;

    logic            write_active;
    logic [7:0]      write_data;
    logic            tgt_full;
    logic            tgt_empty;
    logic            tgt_flush;
    logic            hdr_empty;

    function automatic logic pick(input logic [2:0] v, input logic [1:0] a);
        case (a)
            2'd0:    return v[0];
            2'd1:    return v[1];
            2'd2:    return v[2];
            default: return 1'b0;
        endcase
    endfunction

    assign read_req     = {read_enb_2, read_enb_1, read_enb_0};
    assign write_active = (state == LOAD_FIRST) || (state == LOAD_DATA);
    assign write_data   = (state == LOAD_FIRST) ? header_reg : data_in;
    assign tgt_full     = pick(full, addr_reg);
    assign tgt_empty    = pick(empty, addr_reg);
    assign tgt_flush    = pick(soft_rst, addr_reg);
    assign hdr_empty    = pick(empty, data_in[1:0]);

    for (genvar k = 0; k < 3; k++) begin : g_fifo
        logic [7:0]    mem [DEPTH];
        logic [AW-1:0] wr_ptr;
        logic [AW-1:0] rd_ptr;
        logic [AW:0]   count;
        logic [CW-1:0] idle_cnt;
        logic [7:0]    dout;

        assign full[k]      = (count == FULL_COUNT);
        assign empty[k]     = (count == '0);
        assign rd_en[k]     = read_req[k] && !empty[k];
        assign wr_en[k]     = write_active && (addr_reg == 2'(k)) && !full[k];
        assign soft_rst[k]  = !empty[k] && !read_req[k] && (idle_cnt == LAST_IDLE);
        assign valid_vec[k] = !empty[k];
        assign dout_vec[k]  = dout;

        always_ff @(posedge clock) begin
            if (wr_en[k]) begin
                mem[wr_ptr] <= write_data;
            end
        end

        // A flush never coincides with a read since it needs read_enb low that cycle
        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                idle_cnt <= '0;
                dout     <= '0;
            end else begin
                if (rd_en[k]) begin
                    dout <= mem[rd_ptr];
                end
                if (soft_rst[k]) begin
                    wr_ptr   <= '0;
                    rd_ptr   <= '0;
                    count    <= '0;
                    idle_cnt <= '0;
                end else begin
                    if (wr_en[k]) begin
                        wr_ptr <= wr_ptr + 1'b1;
                    end
                    if (rd_en[k]) begin
                        rd_ptr <= rd_ptr + 1'b1;
                    end
                    if (wr_en[k] && !rd_en[k]) begin
                        count <= count + 1'b1;
                    end else if (!wr_en[k] && rd_en[k]) begin
                        count <= count - 1'b1;
                    end
                    if (read_req[k] || empty[k]) begin
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign data_out_0  = dout_vec[0];
    assign data_out_1  = dout_vec[1];
    assign data_out_2  = dout_vec[2];
    assign valid_out_0 = valid_vec[0];
    assign valid_out_1 = valid_vec[1];
    assign valid_out_2 = valid_vec[2];

    always_comb begin
        busy = 1'b0;
        case (state)
            LOAD_FIRST, WAIT_EMPTY, FIFO_FULL, CHECK_PARITY: busy = 1'b1;
            LOAD_DATA:                                       busy = tgt_full;
            default:                                         busy = 1'b0;
        endcase
    end

    // Flushing the FIFO a packet is heading for abandons that packet
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= DECODE;
            header_reg  <= '0;
            addr_reg    <= '0;
            parity_acc  <= '0;
            recv_parity <= '0;
            error       <= 1'b0;
        end else if (state != DECODE && state != DROP && tgt_flush) begin
            state <= DECODE;
        end else begin
            case (state)
                DECODE: begin
                    if (pkt_valid) begin
                        if (data_in[1:0] == 2'd3) begin
                            state <= DROP;
                        end else begin
                            header_reg <= data_in;
                            addr_reg   <= data_in[1:0];
                            parity_acc <= data_in;
                            error      <= 1'b0;
                            state      <= hdr_empty ? LOAD_FIRST : WAIT_EMPTY;
                        end
                    end
                end
                WAIT_EMPTY: begin
                    if (tgt_empty) begin
                        state <= LOAD_FIRST;
                    end
                end
                LOAD_FIRST: begin
                    state <= LOAD_DATA;
                end
                LOAD_DATA: begin
                    if (tgt_full) begin
                        state <= FIFO_FULL;
                    end else if (pkt_valid) begin
                        parity_acc <= parity_acc ^ data_in;
                    end else begin
                        recv_parity <= data_in;
                        state       <= CHECK_PARITY;
                    end
                end
                FIFO_FULL: begin
                    if (!tgt_full) begin
                        state <= LOAD_DATA;
                    end
                end
                CHECK_PARITY: begin
                    error <= (parity_acc != recv_parity);
                    state <= DECODE;
                end
                DROP: begin
                    if (!pkt_valid) begin
                        state <= DECODE;
                    end
                end
                default: begin
                    state <= DECODE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_router_1x3.sv
// Randomized bench for router_1x3: a queue-per-output model of the bytes each reader must see,
// plus directed packets for fill/stall, wait-for-empty, soft flush, drop and parity error cases.
module tb_router_1x3;

    logic       clock = 1'b0;
    logic       resetn;
    logic [7:0] data_in;
    logic       pkt_valid;
    logic [2:0] rd_req;
    logic [7:0] data_out_0;
    logic [7:0] data_out_1;
    logic [7:0] data_out_2;
    logic       valid_out_0;
    logic       valid_out_1;
    logic       valid_out_2;
    logic       busy;
    logic       error;
    logic [2:0] validVec;

    int         testsRun  = 0;
    int         failures  = 0;
    int         readCount [3];
    int         rdMode    [3];
    int         armCount  [3];
    logic       expErr;
    logic [7:0] expQ0 [$];
    logic [7:0] expQ1 [$];
    logic [7:0] expQ2 [$];

    router_1x3 dut (
        .clock       (clock),
        .resetn      (resetn),
        .data_in     (data_in),
        .pkt_valid   (pkt_valid),
        .read_enb_0  (rd_req[0]),
        .read_enb_1  (rd_req[1]),
        .read_enb_2  (rd_req[2]),
        .data_out_0  (data_out_0),
        .data_out_1  (data_out_1),
        .data_out_2  (data_out_2),
        .valid_out_0 (valid_out_0),
        .valid_out_1 (valid_out_1),
        .valid_out_2 (valid_out_2),
        .busy        (busy),
        .error       (error)
    );

    assign validVec = {valid_out_2, valid_out_1, valid_out_0};

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] getDataOut(input int k);
        case (k)
            0:       return data_out_0;
            1:       return data_out_1;
            default: return data_out_2;
        endcase
    endfunction

    function automatic int expSize(input int k);
        case (k)
            0:       return expQ0.size();
            1:       return expQ1.size();
            default: return expQ2.size();
        endcase
    endfunction

    task automatic pushExp(input int k, input logic [7:0] b);
        case (k)
            0:       expQ0.push_back(b);
            1:       expQ1.push_back(b);
            default: expQ2.push_back(b);
        endcase
    endtask

    function automatic logic [7:0] popExp(input int k);
        case (k)
            0:       return expQ0.pop_front();
            1:       return expQ1.pop_front();
            default: return expQ2.pop_front();
        endcase
    endfunction

    task automatic setRead(input int k, input int mode);
        rdMode[k] = mode;
        rd_req[k] = (mode != 0);
    endtask

    // One clock: every read that fires must deliver the oldest byte the model still holds
    task automatic stepCycle();
        logic [2:0] fired;
        fired = rd_req & validVec;
        @(posedge clock);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (fired[k]) begin
                readCount[k]++;
                checkOutput($sformatf("fifo%0d_has_data", k), 32'(expSize(k) > 0), 32'd1);
                if (expSize(k) > 0) begin
                    checkOutput($sformatf("data_out_%0d", k), 32'(getDataOut(k)), 32'(popExp(k)));
                end
            end
        end
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            if (armCount[k] > 0 && validVec[k]) begin
                armCount[k]--;
                if (armCount[k] == 0) begin
                    checkOutput($sformatf("busy_before_reader_%0d", k), 32'(busy), 32'd1);
                    rdMode[k] = 1;
                end
            end
            case (rdMode[k])
                1:       rd_req[k] = 1'b1;
                2:       rd_req[k] = ($urandom_range(0, 9) < 7);
                default: rd_req[k] = 1'b0;
            endcase
        end
    endtask

    task automatic stepN(input int n);
        for (int i = 0; i < n; i++) begin
            stepCycle();
        end
    endtask

    // Present a byte and hold it until the router accepts it on an edge where busy is low
    task automatic sendByte(input logic [7:0] b, input logic v);
        int guard;
        data_in   = b;
        pkt_valid = v;
        guard     = 0;
        while (busy === 1'b1 && guard < 300) begin
            stepCycle();
            guard++;
        end
        if (guard >= 300) begin
            checkOutput("busy_timeout", 32'(busy), 32'd0);
        end
        stepCycle();
    endtask

    task automatic applyStimulus(input logic [7:0] header, input int len, input bit badParity);
        logic [7:0] payload [$];
        logic [7:0] parity;
        int         addr;
        addr   = int'(header[1:0]);
        parity = header;
        for (int i = 0; i < len; i++) begin
            payload.push_back(8'($urandom));
            parity ^= payload[i];
        end
        if (badParity) begin
            parity ^= 8'($urandom_range(1, 255));
        end
        if (addr != 3) begin
            pushExp(addr, header);
            for (int i = 0; i < len; i++) begin
                pushExp(addr, payload[i]);
            end
            pushExp(addr, parity);
        end
        sendByte(header, 1'b1);
        if (addr != 3) begin
            checkOutput("error_cleared_by_header", 32'(error), 32'd0);
        end
        for (int i = 0; i < len; i++) begin
            sendByte(payload[i], 1'b1);
        end
        sendByte(parity, 1'b0);
        stepCycle();
        if (addr != 3) begin
            expErr = badParity;
            checkOutput("parity_error", 32'(error), 32'(expErr));
        end else begin
            checkOutput("drop_keeps_error", 32'(error), 32'(expErr));
        end
    endtask

    task automatic drainAll(input int cycles);
        for (int k = 0; k < 3; k++) begin
            setRead(k, 1);
        end
        stepN(cycles);
        for (int k = 0; k < 3; k++) begin
            setRead(k, 0);
        end
        stepCycle();
    endtask

    initial begin
        int base;
        resetn    = 1'b0;
        data_in   = 8'h00;
        pkt_valid = 1'b0;
        rd_req    = 3'b000;
        expErr    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            readCount[k] = 0;
            rdMode[k]    = 0;
            armCount[k]  = 0;
        end

        @(negedge clock);
        checkOutput("reset_valid_out_0", 32'(valid_out_0), 32'd0);
        checkOutput("reset_valid_out_1", 32'(valid_out_1), 32'd0);
        checkOutput("reset_valid_out_2", 32'(valid_out_2), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_error", 32'(error), 32'd0);
        checkOutput("reset_data_out_0", 32'(data_out_0), 32'd0);
        checkOutput("reset_data_out_1", 32'(data_out_1), 32'd0);
        checkOutput("reset_data_out_2", 32'(data_out_2), 32'd0);
        resetn = 1'b1;
        stepCycle();

        // Sixteen bytes into FIFO0 with nobody reading, then drained in order
        applyStimulus(8'h38, 14, 1'b0);
        checkOutput("fill0_valid_out_0", 32'(valid_out_0), 32'd1);
        checkOutput("fill0_busy_idle", 32'(busy), 32'd0);
        base = readCount[0];
        setRead(0, 1);
        stepN(20);
        setRead(0, 0);
        checkOutput("fill0_bytes_read", 32'(readCount[0] - base), 32'd16);
        checkOutput("fill0_valid_after_drain", 32'(valid_out_0), 32'd0);

        // Address 1 only touches FIFO1
        applyStimulus(8'h29, 10, 1'b0);
        checkOutput("addr1_valid_out_0", 32'(valid_out_0), 32'd0);
        checkOutput("addr1_valid_out_1", 32'(valid_out_1), 32'd1);
        checkOutput("addr1_valid_out_2", 32'(valid_out_2), 32'd0);
        base = readCount[1];
        setRead(1, 1);
        stepN(16);
        setRead(1, 0);
        checkOutput("addr1_bytes_read", 32'(readCount[1] - base), 32'd12);
        checkOutput("addr1_valid_after_drain", 32'(valid_out_1), 32'd0);

        // Eighteen bytes into FIFO2: the reader starts only once it has filled and stalled the source
        base        = readCount[2];
        armCount[2] = 20;
        applyStimulus(8'h42, 16, 1'b0);
        stepN(20);
        setRead(2, 0);
        checkOutput("full2_bytes_read", 32'(readCount[2] - base), 32'd18);
        checkOutput("full2_valid_after_drain", 32'(valid_out_2), 32'd0);

        // Second packet for an occupied FIFO1 waits until the reader empties it
        applyStimulus(8'h09, 2, 1'b0);
        base        = readCount[1];
        armCount[1] = 5;
        applyStimulus(8'h0D, 3, 1'b0);
        stepN(15);
        setRead(1, 0);
        checkOutput("wait1_bytes_read", 32'(readCount[1] - base), 32'd9);
        checkOutput("wait1_valid_after_drain", 32'(valid_out_1), 32'd0);

        // Soft flush: one read restarts the idle count, thirty idle cycles later FIFO1 is emptied
        applyStimulus(8'h0D, 3, 1'b0);
        setRead(1, 1);
        stepCycle();
        setRead(1, 0);
        stepN(29);
        checkOutput("flush_not_yet", 32'(valid_out_1), 32'd1);
        stepCycle();
        checkOutput("flush_done", 32'(valid_out_1), 32'd0);
        expQ1.delete();

        // Bad parity raises error, a dropped packet leaves it, the next good header clears it
        setRead(0, 2);
        applyStimulus(8'h10, 4, 1'b1);
        checkOutput("bad_parity_error", 32'(error), 32'd1);
        drainAll(12);
        applyStimulus(8'h0B, 2, 1'b0);
        checkOutput("drop_valid_out_0", 32'(valid_out_0), 32'd0);
        checkOutput("drop_valid_out_1", 32'(valid_out_1), 32'd0);
        checkOutput("drop_valid_out_2", 32'(valid_out_2), 32'd0);
        checkOutput("drop_error_held", 32'(error), 32'd1);
        setRead(0, 2);
        applyStimulus(8'h04, 1, 1'b0);
        drainAll(10);

        // Asynchronous reset in the middle of a packet discards everything at once
        sendByte(8'h0E, 1'b1);
        sendByte(8'hA5, 1'b1);
        sendByte(8'h5A, 1'b1);
        resetn = 1'b0;
        #1;
        checkOutput("async_reset_valid_out_2", 32'(valid_out_2), 32'd0);
        checkOutput("async_reset_busy", 32'(busy), 32'd0);
        checkOutput("async_reset_data_out_2", 32'(data_out_2), 32'd0);
        expQ0.delete();
        expQ1.delete();
        expQ2.delete();
        expErr = 1'b0;
        @(negedge clock);
        resetn    = 1'b1;
        pkt_valid = 1'b0;
        stepN(2);
        checkOutput("after_reset_valid_out_2", 32'(valid_out_2), 32'd0);
        checkOutput("after_reset_error", 32'(error), 32'd0);

        // Random packets against randomly paced readers
        for (int k = 0; k < 3; k++) begin
            setRead(k, 2);
        end
        for (int p = 0; p < 25; p++) begin
            int len;
            len = $urandom_range(1, 20);
            applyStimulus({6'(len), 2'($urandom_range(0, 3))}, len, ($urandom_range(0, 4) == 0));
        end
        drainAll(60);
        checkOutput("final_valid_out_0", 32'(valid_out_0), 32'd0);
        checkOutput("final_valid_out_1", 32'(valid_out_1), 32'd0);
        checkOutput("final_valid_out_2", 32'(valid_out_2), 32'd0);
        checkOutput("final_left_in_model", 32'(expSize(0) + expSize(1) + expSize(2)), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
